led_scroll_sink: RTL and testbench

- Receiving end of the character-column write stream produced by the message generator: `write` strobe, `char_in`, and `column` (0..3, one glyph column per beat).
- Each beat does three things:
  - looks up the 8-pixel column bitmap of the glyph;
  - shifts it into a NUM_COLS-wide frame buffer, so the display scrolls left;
  - checks the column sequence.
- A row-multiplexed scanner drives the LED matrix from the frame buffer.

---
 rtl/led_pkg.sv | 89 ++++++++
 rtl/led_scroll_sink_font_rom.sv | 33 +++
 rtl/led_scroll_sink.sv | 112 +++++++++++
 tb/tb_led_scroll_sink.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared font definitions for the LED scroll sink: glyph geometry, the
// supported character codes and the column bitmap table.
package led_pkg;

  localparam int GLYPH_W = 4;
  localparam int GLYPH_H = 8;

  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_DASH   = 8'h2D;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_Z      = 8'h5A;

  typedef logic [GLYPH_H-1:0] col_bits_t;

  typedef struct packed {
    logic [7:0] code;
    logic [1:0] col;
  } beat_t;

  // Packed as {col0, col1, col2}; bit r of each byte is row r, row 0 on top.
  function automatic logic [23:0] glyph_cols(input logic [7:0] code);
    logic [23:0] w_cols;
    case (code)
      CH_SPACE:  w_cols = 24'h000000;
      CH_LPAREN: w_cols = 24'h3E4100;
      CH_RPAREN: w_cols = 24'h00413E;
      CH_DASH:   w_cols = 24'h080808;
      CH_COLON:  w_cols = 24'h001400;
      8'h30:     w_cols = 24'h7F417F;
      8'h31:     w_cols = 24'h427F40;
      8'h32:     w_cols = 24'h79494F;
      8'h33:     w_cols = 24'h41497F;
      8'h34:     w_cols = 24'h0F087F;
      8'h35:     w_cols = 24'h4F4979;
      8'h36:     w_cols = 24'h7F4979;
      8'h37:     w_cols = 24'h01017F;
      8'h38:     w_cols = 24'h7F497F;
      8'h39:     w_cols = 24'h4F497F;
      8'h41:     w_cols = 24'h7E097E;
      8'h42:     w_cols = 24'h7F4936;
      8'h43:     w_cols = 24'h3E4141;
      8'h44:     w_cols = 24'h7F413E;
      8'h45:     w_cols = 24'h7F4941;
      8'h46:     w_cols = 24'h7F0901;
      8'h47:     w_cols = 24'h3E4179;
      8'h48:     w_cols = 24'h7F087F;
      8'h49:     w_cols = 24'h417F41;
      8'h4A:     w_cols = 24'h20403F;
      8'h4B:     w_cols = 24'h7F0877;
      8'h4C:     w_cols = 24'h7F4040;
      8'h4D:     w_cols = 24'h7F067F;
      8'h4E:     w_cols = 24'h7F1C7F;
      8'h4F:     w_cols = 24'h3E413E;
      8'h50:     w_cols = 24'h7F0906;
      8'h51:     w_cols = 24'h3E617E;
      8'h52:     w_cols = 24'h7F1966;
      8'h53:     w_cols = 24'h464931;
      8'h54:     w_cols = 24'h017F01;
      8'h55:     w_cols = 24'h3F403F;
      8'h56:     w_cols = 24'h1F601F;
      8'h57:     w_cols = 24'h7F307F;
      8'h58:     w_cols = 24'h770877;
      8'h59:     w_cols = 24'h077807;
      8'h5A:     w_cols = 24'h714947;
      default:   w_cols = 24'h000000;
    endcase
    return w_cols;
  endfunction

  // Column 3 is always the blank inter-character gap.
  function automatic col_bits_t glyph_column(input logic [7:0] code, input logic [1:0] col);
    logic [23:0] w_cols;
    col_bits_t   w_bits;
    w_cols = glyph_cols(code);
    case (col)
      2'd0:    w_bits = w_cols[23:16];
      2'd1:    w_bits = w_cols[15:8];
      2'd2:    w_bits = w_cols[7:0];
      default: w_bits = '0;
    endcase
    return w_bits;
  endfunction

endpackage

// File: rtl/led_scroll_sink_font_rom.sv
// Registered font lookup: one glyph column bitmap per accepted beat, one
// cycle after the beat is presented.
module font_rom
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic [1:0] column,
  input  logic       valid_in,
  output logic [7:0] bitmap,
  output logic       valid_out
);

  logic [7:0] r_bitmap;
  logic       r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitmap <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_bitmap <= glyph_column(char_in, column);
      end
    end
  end

  assign bitmap    = r_bitmap;
  assign valid_out = r_valid;

endmodule

// File: rtl/led_scroll_sink.sv
// Receives glyph-column beats, scrolls them into a frame buffer and drives a
// row-multiplexed LED matrix from it; also checks the column sequence.
module led_scroll_sink
  import led_pkg::*;
#(
  parameter int NUM_COLS = 16,
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic [7:0]          char_in,
  input  logic [1:0]          column,
  output logic [7:0]          row_sel,
  output logic [NUM_COLS-1:0] col_out,
  output logic                seq_err,
  output logic [7:0]          char_count
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  beat_t               r_beat;
  logic                r_valid;
  logic [1:0]          r_expected;
  logic                r_seq_err;
  logic [7:0]          r_char_count;

  logic [7:0]          w_bitmap;
  logic                w_bitmap_valid;

  logic [7:0]          r_fb [NUM_COLS];

  logic [PW-1:0]       r_presc;
  logic [2:0]          r_row;
  logic [7:0]          r_row_sel;
  logic [NUM_COLS-1:0] r_col_out;
  logic                w_tick;

  // A mismatched column still resyncs the expectation so one glitch flags once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat       <= '0;
      r_valid      <= 1'b0;
      r_expected   <= 2'd0;
      r_seq_err    <= 1'b0;
      r_char_count <= 8'd0;
    end else begin
      r_valid <= write;
      if (write) begin
        r_beat     <= '{code: char_in, col: column};
        r_expected <= column + 2'd1;
        if (column != r_expected) begin
          r_seq_err <= 1'b1;
        end
        if (column == 2'd3) begin
          r_char_count <= r_char_count + 8'd1;
        end
      end
    end
  end

  font_rom u_font_rom (
    .clk       (clk),
    .rst       (rst),
    .char_in   (r_beat.code),
    .column    (r_beat.col),
    .valid_in  (r_valid),
    .bitmap    (w_bitmap),
    .valid_out (w_bitmap_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        r_fb[i] <= '0;
      end
    end else if (w_bitmap_valid) begin
      for (int i = NUM_COLS - 1; i > 0; i--) begin
        r_fb[i] <= r_fb[i-1];
      end
      r_fb[0] <= w_bitmap;
    end
  end

  assign w_tick = (r_presc == PRESC_LAST);

  // Row capture reads r_fb before any same-edge shift lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_row     <= 3'd0;
      r_row_sel <= 8'd0;
      r_col_out <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_row_sel <= 8'd1 << r_row;
        for (int i = 0; i < NUM_COLS; i++) begin
          r_col_out[i] <= r_fb[i][r_row];
        end
        r_row <= r_row + 3'd1;
      end
    end
  end

  assign row_sel    = r_row_sel;
  assign col_out    = r_col_out;
  assign seq_err    = r_seq_err;
  assign char_count = r_char_count;

endmodule

// File: tb/tb_led_scroll_sink.sv
// Scoreboard bench for led_scroll_sink: stimulus queues expected row images,
// a monitor pops them as the scanner presents each row.
module tb_led_scroll_sink;

  logic       clk = 1'b0;
  logic       rst;
  logic       write;
  logic [7:0] char_in;
  logic [1:0] column;
  logic [7:0] row_sel;
  logic [7:0] col_out;
  logic       seq_err;
  logic [7:0] char_count;

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] col;
    logic       err;
    logic [7:0] cnt;
    logic [7:0] phase;
  } exp_t;

  exp_t expQ[$];
  int   numChecks = 0;
  int   numErrors = 0;

  led_scroll_sink #(.NUM_COLS(8), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .char_in    (char_in),
    .column     (column),
    .row_sel    (row_sel),
    .col_out    (col_out),
    .seq_err    (seq_err),
    .char_count (char_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic [1:0] col);
    write   = 1'b1;
    char_in = code;
    column  = col;
    @(negedge clk);
  endtask

  task automatic runChar(input logic [7:0] code);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(code, 2'(c));
    end
  endtask

  task automatic idleCycles(input int n);
    write = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // rows holds row r's expected col_out in byte r.
  task automatic pushFrame(input int phase, input logic [63:0] rows, input logic err, input logic [7:0] cnt);
    exp_t e;
    for (int r = 0; r < 8; r++) begin
      e.row   = 3'(r);
      e.col   = rows[8*r +: 8];
      e.err   = err;
      e.cnt   = cnt;
      e.phase = 8'(phase);
      expQ.push_back(e);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 150) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      numChecks++;
      numErrors++;
      $display("[TB] FAIL drain_timeout: %0d rows still pending, want 0", expQ.size());
      expQ.delete();
    end
  endtask

  // Monitor: models the row walk and tick period, and scores queued rows.
  logic [7:0] prevSel;
  logic [2:0] expRow;
  int         tickGap;
  exp_t       cur;

  always @(negedge clk) begin
    if (rst) begin
      prevSel = 8'd0;
      expRow  = 3'd0;
      tickGap = 0;
    end else begin
      tickGap++;
      if (row_sel != prevSel) begin
        checkOutput("row_sel_walk", 32'(row_sel), 32'(8'd1 << expRow));
        checkOutput("tick_period", 32'(tickGap), 32'd4);
        if (expQ.size() > 0 && expQ[0].row == expRow) begin
          cur = expQ.pop_front();
          checkOutput($sformatf("p%0d_row%0d_col_out", cur.phase, cur.row), 32'(col_out), 32'(cur.col));
          checkOutput($sformatf("p%0d_seq_err", cur.phase), 32'(seq_err), 32'(cur.err));
          checkOutput($sformatf("p%0d_char_count", cur.phase), 32'(char_count), 32'(cur.cnt));
        end
        prevSel = row_sel;
        expRow  = expRow + 3'd1;
        tickGap = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; write = 1'b0; char_in = 8'h00; column = 2'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst_row_sel", 32'(row_sel), 32'h0);
    checkOutput("rst_seq_err", 32'(seq_err), 32'h0);
    checkOutput("rst_char_count", 32'(char_count), 32'h0);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("pre_tick_row_sel", 32'(row_sel), 32'h0);
      checkOutput("pre_tick_col_out", 32'(col_out), 32'h0);
    end
    @(negedge clk);
    checkOutput("first_tick_row_sel", 32'(row_sel), 32'h01);
    pushFrame(0, 64'h0, 1'b0, 8'd0);
    waitDrain();

    runChar(8'h2D);
    idleCycles(3);
    pushFrame(1, 64'h00000000_0E000000, 1'b0, 8'd1);
    waitDrain();

    runChar(8'h41);
    runChar(8'h2D);
    idleCycles(3);
    pushFrame(2, 64'h00A0A0A0_EEA0A040, 1'b0, 8'd3);
    waitDrain();

    applyStimulus(8'h20, 2'd0);
    idleCycles(3);
    pushFrame(3, 64'h00404040_DC404080, 1'b0, 8'd3);
    waitDrain();

    applyStimulus(8'h20, 2'd1);
    applyStimulus(8'h20, 2'd2);
    applyStimulus(8'h20, 2'd3);
    runChar(8'h7F);
    idleCycles(3);
    pushFrame(4, 64'h0, 1'b0, 8'd5);
    waitDrain();

    runChar(8'h31);
    runChar(8'h3A);
    idleCycles(3);
    pushFrame(5, 64'h00E04044_4044C040, 1'b0, 8'd7);
    waitDrain();

    applyStimulus(8'h2D, 2'd0);
    applyStimulus(8'h2D, 2'd1);
    checkOutput("seq_ok_before_skip", 32'(seq_err), 32'h0);
    applyStimulus(8'h2D, 2'd3);
    checkOutput("seq_err_on_skip", 32'(seq_err), 32'h1);
    applyStimulus(8'h2D, 2'd0);
    checkOutput("seq_err_sticky", 32'(seq_err), 32'h1);
    checkOutput("count_after_skip", 32'(char_count), 32'd8);
    idleCycles(3);
    pushFrame(6, 64'h00000040_0D400000, 1'b1, 8'd8);
    waitDrain();

    applyStimulus(8'h2D, 2'd0);
    write = 1'b1; char_in = 8'h2D; column = 2'd1;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_row_sel", 32'(row_sel), 32'h0);
    checkOutput("async_rst_col_out", 32'(col_out), 32'h0);
    checkOutput("async_rst_seq_err", 32'(seq_err), 32'h0);
    checkOutput("async_rst_char_count", 32'(char_count), 32'h0);
    write = 1'b0;
    expQ.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    runChar(8'h2D);
    checkOutput("fresh_seq_err", 32'(seq_err), 32'h0);
    idleCycles(3);
    pushFrame(7, 64'h00000000_0E000000, 1'b0, 8'd1);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
